// File: rtl/psum_buf_pkg.sv
// Shared types and defaults for the partial-sum buffer and the conv accumulator top.
package psum_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DRAIN_FIFO_DEPTH = 2;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int DEPTH      = 1024;

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port partial-sum storage: one write port, one registered read port, no reset.
module psum_ram #(
  parameter int DataWidth = 32,
  parameter int AddrBits  = 10,
  parameter int Depth     = 1024
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrBits-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrBits-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psum_buffer.sv
// Partial-sum buffer: live conv read/write port in IDLE, plus host-driven clear and
// valid/ready drain sequences that own the RAM while busy.
module psum_buffer
  import psum_buf_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int Depth     = DEPTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [AddrWidth-1:0] rd_addr_conv,
  output logic [DataWidth-1:0] rd_data_conv,
  input  logic [AddrWidth-1:0] wr_addr_conv,
  input  logic [DataWidth-1:0] wr_data_conv,
  input  logic                 wr_en_conv,
  input  logic                 clear_start,
  input  logic [AddrWidth-1:0] clear_len,
  input  logic                 drain_start,
  input  logic [AddrWidth-1:0] drain_len,
  output logic                 busy,
  output logic                 done,
  output logic                 conflict,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int LW = AddrWidth + 1;
  localparam int MW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(Depth);
  localparam logic [LW-1:0] ONE     = LW'(1);

  state_t                      state;
  logic [LW-1:0]               rp, len_q;
  logic                        armed, ram_v, ram_last;
  logic [1:0]                  count;
  logic                        rd_ptr, wr_ptr;
  logic [DataWidth-1:0]        fifo_data [DRAIN_FIFO_DEPTH];
  logic [DRAIN_FIFO_DEPTH-1:0] fifo_last;

  logic                        ram_we;
  logic [MW-1:0]               ram_waddr, ram_raddr;
  logic [DataWidth-1:0]        ram_wdata, ram_rdata;

  logic                        conv_zero, conv_fwd;
  logic [DataWidth-1:0]        conv_fwd_data;

  logic                        rd_oob, wr_oob, pop, issue;
  logic [LW-1:0]               clear_n, drain_n;
  logic [2:0]                  occ, room;

  function automatic logic [LW-1:0] clamp_len(input logic [AddrWidth-1:0] len);
    return ({1'b0, len} > DEPTH_L) ? DEPTH_L : {1'b0, len};
  endfunction

  assign clear_n = clamp_len(clear_len);
  assign drain_n = clamp_len(drain_len);
  assign rd_oob  = {1'b0, rd_addr_conv} >= DEPTH_L;
  assign wr_oob  = {1'b0, wr_addr_conv} >= DEPTH_L;

  assign m_valid = count != 2'd0;
  assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last  = m_valid & fifo_last[rd_ptr];
  assign pop     = m_valid & m_ready;

  // A beat leaving this cycle frees a slot, so it counts as room for a new read;
  // otherwise the 2-cycle issue-to-FIFO loop could not sustain one beat per cycle.
  assign occ   = {1'b0, count} + {2'b0, ram_v};
  assign room  = 3'(DRAIN_FIFO_DEPTH) + {2'b0, pop};
  assign issue = (state == DRAIN) && armed && (rp < len_q) && (occ < room);

  assign ram_raddr = (state == DRAIN) ? rp[MW-1:0] : rd_addr_conv[MW-1:0];

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr_conv[MW-1:0];
    ram_wdata = wr_data_conv;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = rp[MW-1:0];
      ram_wdata = '0;
    end else if (state == IDLE) begin
      ram_we = wr_en_conv && !wr_oob;
    end
  end

  psum_ram #(
    .DataWidth (DataWidth),
    .AddrBits  (MW),
    .Depth     (Depth)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rd_data_conv = conv_zero ? '0 : (conv_fwd ? conv_fwd_data : ram_rdata);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      conflict <= 1'b0;
      rp       <= '0;
      len_q    <= '0;
      armed    <= 1'b0;
      ram_v    <= 1'b0;
      ram_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      ram_v    <= issue;
      ram_last <= (rp == len_q - ONE);
      if (wr_en_conv && state != IDLE) conflict <= 1'b1;
      unique case (state)
        IDLE: begin
          rp    <= '0;
          armed <= 1'b0;
          if (clear_start) begin
            if (clear_n == '0) done <= 1'b1;
            else begin
              state <= CLEAR;
              busy  <= 1'b1;
              len_q <= clear_n;
            end
          end else if (drain_start) begin
            if (drain_n == '0) done <= 1'b1;
            else begin
              state <= DRAIN;
              busy  <= 1'b1;
              len_q <= drain_n;
            end
          end
        end
        CLEAR: begin
          rp <= rp + ONE;
          if (rp == len_q - ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DRAIN: begin
          armed <= 1'b1;
          if (issue) rp <= rp + ONE;
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count         <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_last     <= '0;
      conv_zero     <= 1'b1;
      conv_fwd      <= 1'b0;
      conv_fwd_data <= '0;
      for (int unsigned i = 0; i < DRAIN_FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      if (ram_v) begin
        fifo_data[wr_ptr] <= ram_rdata;
        fifo_last[wr_ptr] <= ram_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count         <= count + {1'b0, ram_v} - {1'b0, pop};
      conv_zero     <= (state != IDLE) || rd_oob;
      conv_fwd      <= wr_en_conv && (wr_addr_conv == rd_addr_conv);
      conv_fwd_data <= wr_data_conv;
    end
  end

endmodule

// File: tb/tb_psum_buffer.sv
// Scoreboard bench for psum_buffer: conv reads and drain beats are queued when driven
// and compared when the DUT presents them.
module tb_psum_buffer;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 1024;

  logic          Clk, Rst;
  logic [AW-1:0] rd_addr_conv, wr_addr_conv, clear_len, drain_len;
  logic [DW-1:0] rd_data_conv, wr_data_conv, m_data;
  logic          wr_en_conv, clear_start, drain_start;
  logic          busy, done, conflict, m_valid, m_ready, m_last;

  psum_buffer #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEP)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .rd_addr_conv (rd_addr_conv),
    .rd_data_conv (rd_data_conv),
    .wr_addr_conv (wr_addr_conv),
    .wr_data_conv (wr_data_conv),
    .wr_en_conv   (wr_en_conv),
    .clear_start  (clear_start),
    .clear_len    (clear_len),
    .drain_start  (drain_start),
    .drain_len    (drain_len),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
  );

  int            n_total = 0;
  int            n_bad   = 0;
  int            hs_total = 0;
  logic [DW-1:0] model [DEP];
  logic [DW-1:0] rd_q [$];
  logic [DW:0]   drain_q [$];
  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  logic [DW:0]   mon_e;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic conv(input logic rd, input logic [AW-1:0] ra, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic idle);
    logic [DW-1:0] e;
    rd_addr_conv = ra;
    wr_en_conv   = we;
    wr_addr_conv = wa;
    wr_data_conv = wd;
    rd_req       = rd;
    if (rd) begin
      if (!idle || int'(ra) >= DEP) e = '0;
      else if (we && wa == ra)      e = wd;
      else                          e = model[ra];
      rd_q.push_back(e);
    end
    if (we && idle && int'(wa) < DEP) model[wa] = wd;
    tick;
    rd_req     = 1'b0;
    wr_en_conv = 1'b0;
  endtask

  always @(posedge Clk) rd_pend <= rd_req;

  always @(negedge Clk) begin
    if (!Rst) begin
      stall = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL rd_unexpected got=%0h exp=none", rd_data_conv);
        end else check("rd_data", rd_data_conv, rd_q.pop_front());
      end
      if (stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, held_data);
        check("hold_last", 32'(m_last), 32'(held_last));
      end
      if (m_valid && m_ready) begin
        hs_total++;
        if (drain_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL beat_unexpected got=%0h exp=none", m_data);
        end else begin
          mon_e = drain_q.pop_front();
          check("beat_data", m_data, mon_e[DW-1:0]);
          check("beat_last", 32'(m_last), 32'(mon_e[DW]));
        end
      end
      stall     = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
    end
  end

  task automatic drain(input int n, input int mode, input logic poke_clear,
                       output int first_k, output int done_k);
    int k;
    for (int i = 0; i < n; i++) drain_q.push_back({i == n - 1, model[i]});
    drain_len   = AW'(n);
    drain_start = 1'b1;
    m_ready     = 1'b1;
    tick;
    drain_start = 1'b0;
    first_k = -1;
    done_k  = -1;
    k = 0;
    while (k < 200) begin
      if (first_k < 0 && m_valid) first_k = k;
      if (done) begin
        done_k = k;
        break;
      end
      clear_start = poke_clear && (k == 4);
      clear_len   = 16'd2;
      m_ready     = (mode == 0) || (k % 3 == 0);
      tick;
      k++;
    end
    clear_start = 1'b0;
    m_ready     = 1'b1;
    check("drain_done_seen", 32'(done_k >= 0), 32'd1);
    check("drain_busy_after", 32'(busy), 32'd0);
    check("drain_q_empty", 32'(drain_q.size()), 32'd0);
  endtask

  int fk, dk, cnt, base;

  initial begin
    Rst = 1'b0;
    rd_addr_conv = '0; wr_addr_conv = '0; wr_data_conv = '0; wr_en_conv = 1'b0;
    clear_start = 1'b0; clear_len = '0; drain_start = 1'b0; drain_len = '0; m_ready = 1'b1;
    repeat (3) tick;
    check("rst_rd_data", rd_data_conv, 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    Rst = 1'b1;
    tick;

    // junk first so the clear has something to overwrite
    for (int i = 0; i < 8; i++) conv(1'b0, '0, 1'b1, AW'(i), 32'hA0 + i, 1'b1);
    clear_start = 1'b1;
    clear_len   = 16'd8;
    tick;
    clear_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd8);
    check("clear_done", 32'(done), 32'd1);
    tick;
    check("clear_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 8; i++) conv(1'b1, AW'(i), 1'b0, '0, '0, 1'b1);

    conv(1'b0, '0, 1'b1, 16'd3, 32'h10, 1'b1);
    conv(1'b1, 16'd3, 1'b0, '0, '0, 1'b1);
    conv(1'b1, 16'd3, 1'b1, 16'd3, 32'h20, 1'b1);
    conv(1'b1, 16'd3, 1'b0, '0, '0, 1'b1);
    conv(1'b0, '0, 1'b1, 16'd976, 32'h33, 1'b1);
    conv(1'b0, '0, 1'b1, 16'd2000, 32'h77, 1'b1);
    conv(1'b1, 16'd2000, 1'b0, '0, '0, 1'b1);
    conv(1'b1, 16'd976, 1'b0, '0, '0, 1'b1);
    conv(1'b0, '0, 1'b1, 16'd1023, 32'h55, 1'b1);
    conv(1'b1, 16'd1023, 1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 6; i++) conv(1'b0, '0, 1'b1, AW'(i), 32'd100 + i, 1'b1);
    drain(6, 0, 1'b0, fk, dk);
    check("drain_first_valid", 32'(fk), 32'd3);
    check("drain_done_cycle", 32'(dk), 32'd9);
    tick;
    drain(6, 1, 1'b0, fk, dk);
    tick;
    drain(6, 0, 1'b1, fk, dk);
    check("poked_done_cycle", 32'(dk), 32'd9);
    tick;
    check("poked_no_clear", 32'(busy), 32'd0);
    conv(1'b1, 16'd0, 1'b0, '0, '0, 1'b1);

    conv(1'b0, '0, 1'b1, 16'd9, 32'h99, 1'b1);
    check("pre_conflict", 32'(conflict), 32'd0);
    clear_start = 1'b1;
    clear_len   = 16'd4;
    tick;
    clear_start = 1'b0;
    conv(1'b1, 16'd5, 1'b1, 16'd9, 32'hDEAD, 1'b0);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick;
    end
    check("conflict_set", 32'(conflict), 32'd1);
    for (int i = 0; i < 4; i++) model[i] = '0;
    conv(1'b1, 16'd9, 1'b0, '0, '0, 1'b1);
    conv(1'b1, 16'd2, 1'b0, '0, '0, 1'b1);
    repeat (3) tick;
    check("conflict_sticky", 32'(conflict), 32'd1);

    for (int i = 0; i < 6; i++) drain_q.push_back({i == 5, model[i]});
    drain_len   = 16'd6;
    drain_start = 1'b1;
    m_ready     = 1'b1;
    tick;
    drain_start = 1'b0;
    base = hs_total;
    cnt  = 0;
    while (hs_total - base < 2 && cnt < 50) begin
      cnt++;
      tick;
    end
    check("rst_two_beats", 32'(hs_total - base), 32'd2);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    #2 Rst = 1'b0;
    #1;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    drain_q.delete();
    rd_q.delete();
    tick;
    check("abort_done_hold", 32'(done), 32'd0);
    Rst = 1'b1;
    tick;
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_conflict", 32'(conflict), 32'd0);
    drain_len   = '0;
    drain_start = 1'b1;
    tick;
    drain_start = 1'b0;
    check("zero_len_done", 32'(done), 32'd1);
    check("zero_len_busy", 32'(busy), 32'd0);
    check("zero_len_valid", 32'(m_valid), 32'd0);
    tick;
    check("zero_len_done_pulse", 32'(done), 32'd0);
    check("zero_len_no_beat", 32'(m_valid), 32'd0);

    clear_start = 1'b1;
    clear_len   = 16'd2000;
    tick;
    clear_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      tick;
    end
    check("clamp_busy_cycles", 32'(cnt), 32'd1024);
    for (int i = 0; i < DEP; i++) model[i] = '0;
    conv(1'b1, 16'd1023, 1'b0, '0, '0, 1'b1);
    repeat (3) tick;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
